// File: rtl/instr_prefetch_queue_if.sv
// Bundle of fetch-side signals for instr_prefetch_queue: the instruction
// memory request/response channel, the redirect input and the IF/ID
// dequeue handshake.
// master: the prefetch queue itself. slave: memory/pipeline/testbench side.
interface instr_prefetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          imem_req_valid;
    logic [63:0]   imem_req_addr;
    logic          imem_req_ready;
    logic          imem_resp_valid;
    logic [31:0]   imem_resp_data;

    logic          redirect_valid;
    logic [63:0]   redirect_pc;

    logic          deq_ready;
    logic          deq_valid;
    logic [63:0]   deq_pc;
    logic [31:0]   deq_instruction;
    logic          deq_inv_addr;
    logic [CW-1:0] queue_count;

    logic [31:0]   perf_fetch_count;
    logic [31:0]   perf_drop_count;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        input  deq_ready,
        output deq_valid, deq_pc, deq_instruction, deq_inv_addr, queue_count,
        output perf_fetch_count, perf_drop_count
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        output deq_ready,
        input  deq_valid, deq_pc, deq_instruction, deq_inv_addr, queue_count,
        input  perf_fetch_count, perf_drop_count
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue sitting in front of the IF/ID register.
// Issues sequential word fetches to a multi-cycle instruction memory,
// buffers returned words tagged with their PC, and hands them to IF/ID
// over a valid/ready handshake (ready = IF_ID_Write). A redirect flushes
// everything and restarts fetching from the new PC.
//
// Build option: define PREFETCH_PERF_CNT_EN to get the fetch/drop
// performance counters; otherwise both counter ports read as zero.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | request fetch_pc when there is room, or enqueue an invalid-
//        | address marker when fetch_pc is misaligned/out of range
// WAIT   | one request accepted, waiting for its response
// DRAIN  | a response belonging to a flushed request is still due; drop it
// HALT   | invalid address reached, idle until the next redirect
module instr_prefetch_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [63:0] IMEM_BYTES = 64'd1024
) (
    input  logic                   clock,
    input  logic                   reset,
    instr_prefetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [63:0]   fetch_pc_q;
    logic [63:0]   req_pc_q;

    logic [63:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic          fifo_inv   [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    logic          fetch_pc_ok;
    logic          inflight;
    logic [CW:0]   occupancy;
    logic          space;
    logic          req_valid;
    logic          req_hs;
    logic          resp_enq;
    logic          inv_enq;
    logic          drop_resp;
    logic          enq;
    logic          deq_valid;
    logic          pop;
    logic [63:0]   enq_pc;
    logic [31:0]   enq_instr;
    logic          enq_inv;

    // A fetch address is usable only if word aligned and inside the memory.
    assign fetch_pc_ok = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q < IMEM_BYTES);

    // Room is reserved for the outstanding response so the FIFO cannot overflow.
    assign inflight  = (state_q == S_WAIT);
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight};
    assign space     = occupancy < (CW + 1)'(DEPTH);

    // FSM state register plus the fetch/request PC registers it steers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 64'h0;
        end else begin
            state_q <= state_d;
            if (req_hs) begin
                req_pc_q <= fetch_pc_q;
            end
            if (bus.redirect_valid) begin
                fetch_pc_q <= bus.redirect_pc;
            end else if (req_hs) begin
                fetch_pc_q <= fetch_pc_q + 64'd4;
            end
        end
    end

    // Next state; a redirect overrides everything and only has to remember
    // whether a response is still owed by the memory.
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            if (req_hs ||
                (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !bus.imem_resp_valid)) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (req_hs) begin
                        state_d = S_WAIT;
                    end else if (!fetch_pc_ok && space) begin
                        state_d = S_HALT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        state_d = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (bus.imem_resp_valid) begin
                        state_d = S_FETCH;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // FSM outputs: memory request, enqueue sources and discarded responses.
    always_comb begin
        req_valid = 1'b0;
        resp_enq  = 1'b0;
        inv_enq   = 1'b0;
        drop_resp = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_valid = !reset && fetch_pc_ok && space;
                inv_enq   = !fetch_pc_ok && space;
            end
            S_WAIT: begin
                resp_enq = bus.imem_resp_valid;
            end
            S_DRAIN: begin
                drop_resp = bus.imem_resp_valid;
            end
            default: begin
                req_valid = 1'b0;
            end
        endcase
    end

    assign req_hs = req_valid && bus.imem_req_ready;

    // A redirect cancels whatever would have entered or left the FIFO.
    assign enq       = (resp_enq || inv_enq) && !bus.redirect_valid;
    assign deq_valid = !reset && (count_q != '0) && !bus.redirect_valid;
    assign pop       = deq_valid && bus.deq_ready;

    assign enq_pc    = resp_enq ? req_pc_q : fetch_pc_q;
    assign enq_instr = resp_enq ? bus.imem_resp_data : NOP_INSTR;
    assign enq_inv   = !resp_enq;

    // FIFO storage, pointers and occupancy; storage is cleared so the head
    // fields read zero out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]    <= 64'h0;
                fifo_instr[i] <= 32'h0;
                fifo_inv[i]   <= 1'b0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) begin
                fifo_pc[wr_ptr_q]    <= enq_pc;
                fifo_instr[wr_ptr_q] <= enq_instr;
                fifo_inv[wr_ptr_q]   <= enq_inv;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({enq, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.imem_req_valid  = req_valid;
    assign bus.imem_req_addr   = fetch_pc_q;
    assign bus.deq_valid       = deq_valid;
    assign bus.deq_pc          = fifo_pc[rd_ptr_q];
    assign bus.deq_instruction = fifo_instr[rd_ptr_q];
    assign bus.deq_inv_addr    = fifo_inv[rd_ptr_q];
    assign bus.queue_count     = count_q;

`ifdef PREFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_drop_q;

    // Accepted fetches, and responses/entries thrown away by redirects.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_q <= 32'h0;
            perf_drop_q  <= 32'h0;
        end else begin
            if (req_hs) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            perf_drop_q <= perf_drop_q + 32'(drop_resp)
                         + (bus.redirect_valid ? 32'(count_q) : 32'd0);
        end
    end

    assign bus.perf_fetch_count = perf_fetch_q;
    assign bus.perf_drop_count  = perf_drop_q;
`else
    assign bus.perf_fetch_count = 32'h0;
    assign bus.perf_drop_count  = 32'h0;
`endif
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: behavioural instruction memory with
// programmable latency, a scoreboard of expected dequeued entries built
// from the bench's own fetch-PC model, a vector table of redirect runs,
// and hand-written sequences for the multi-cycle corner cases.
module tb_instr_prefetch_queue;
    localparam int          DEPTH      = 4;
    localparam logic [63:0] RESET_PC   = 64'h0;
    localparam logic [63:0] IMEM_BYTES = 64'd1024;
`ifdef PREFETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    instr_prefetch_queue_if #(.DEPTH(DEPTH)) bus();

    instr_prefetch_queue #(
        .DEPTH(DEPTH), .RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        inv;
    } entry_t;

    typedef struct {
        logic [63:0] start_pc;
        int          lat;
        int          n_deq;
        logic [63:0] exp_last_pc;
        logic        exp_last_inv;
    } vec_t;

    entry_t      sb[$];
    logic [63:0] deq_log[$];
    logic [31:0] deq_instr_log[$];
    logic        deq_inv_log[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_fetch_pc = RESET_PC;
    logic        mem_pending = 1'b0;
    int          mem_cnt = 0;
    logic [63:0] mem_addr = 64'h0;
    logic [63:0] mem_exp_pc = 64'h0;
    logic        discard = 1'b0;
    logic        inv_pending = 1'b0;
    logic [63:0] inv_pc = 64'h0;
    int          lat = 2;
    int          n_req = 0;
    int          deq_count = 0;
    logic [31:0] exp_fetch_cnt = 32'h0;
    logic [31:0] exp_drop_cnt = 32'h0;

    function automatic logic pc_ok(input logic [63:0] pc);
        return (pc[1:0] == 2'b00) && (pc < IMEM_BYTES);
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        return {addr[15:0] ^ 16'h5A5A, addr[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: sample settled outputs, update scoreboard and models,
    // cross the edge, then drive the memory response for the new cycle.
    task automatic tick();
        logic        hs;
        logic        fire;
        logic        rv;
        logic        disc0;
        logic        inv0;
        logic        redir;
        logic        exp_dv;
        logic [63:0] hs_pc;
        logic [63:0] hs_addr;
        int          size0;
        entry_t      e;
        #1;
        hs      = bus.imem_req_valid && bus.imem_req_ready;
        fire    = bus.deq_valid && bus.deq_ready;
        rv      = bus.imem_resp_valid;
        redir   = bus.redirect_valid;
        disc0   = discard;
        inv0    = inv_pending;
        size0   = sb.size();
        hs_pc   = exp_fetch_pc;
        hs_addr = bus.imem_req_addr;
        if (!reset) begin
            exp_dv = (size0 != 0) && !redir;
            check("queue_count", 64'(bus.queue_count), 64'(size0));
            check("deq_valid", 64'(bus.deq_valid), 64'(exp_dv));
            if (hs) begin
                check("req_addr", bus.imem_req_addr, exp_fetch_pc);
                n_req++;
                exp_fetch_cnt++;
            end
            if (fire && size0 != 0) begin
                e = sb.pop_front();
                check("deq_pc", bus.deq_pc, e.pc);
                check("deq_instruction", 64'(bus.deq_instruction), 64'(e.instr));
                check("deq_inv_addr", 64'(bus.deq_inv_addr), 64'(e.inv));
                deq_log.push_back(bus.deq_pc);
                deq_instr_log.push_back(bus.deq_instruction);
                deq_inv_log.push_back(bus.deq_inv_addr);
                deq_count++;
            end
            if (inv0 && !disc0 && size0 < DEPTH && !redir) begin
                sb.push_back('{inv_pc, 32'h0000_0013, 1'b1});
                inv_pending = 1'b0;
            end
            if (rv) begin
                if (disc0) begin
                    discard = 1'b0;
                    exp_drop_cnt++;
                end else if (!redir) begin
                    sb.push_back('{mem_exp_pc, mem_word(mem_exp_pc), 1'b0});
                    if (!pc_ok(exp_fetch_pc)) begin
                        inv_pending = 1'b1;
                        inv_pc      = exp_fetch_pc;
                    end
                end
            end
            if (redir) begin
                exp_drop_cnt += 32'(size0);
                sb.delete();
                discard      = hs || mem_pending || (disc0 && !rv);
                exp_fetch_pc = bus.redirect_pc;
                inv_pending  = !pc_ok(bus.redirect_pc);
                inv_pc       = bus.redirect_pc;
            end else if (hs) begin
                exp_fetch_pc = exp_fetch_pc + 64'd4;
            end
        end
        @(posedge clock);
        #1;
        if (reset) begin
            sb.delete();
            discard             = 1'b0;
            inv_pending         = 1'b0;
            mem_pending         = 1'b0;
            bus.imem_resp_valid = 1'b0;
            exp_fetch_pc        = RESET_PC;
            exp_fetch_cnt       = 32'h0;
            exp_drop_cnt        = 32'h0;
        end else begin
            bus.imem_resp_valid = 1'b0;
            if (mem_pending) begin
                if (mem_cnt == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = mem_word(mem_addr);
                    mem_pending         = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            if (hs) begin
                mem_pending = 1'b1;
                mem_cnt     = lat - 2;
                mem_addr    = hs_addr;
                mem_exp_pc  = hs_pc;
            end
        end
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic run_until_deq(input string name, input int n, input int max_cycles);
        int start;
        start = deq_count;
        for (int i = 0; i < max_cycles && (deq_count - start) < n; i++) begin
            tick();
        end
        check(name, 64'(deq_count - start), 64'(n));
    endtask

    task automatic check_perf(input string tag);
        check({tag, "_perf_fetch"}, 64'(bus.perf_fetch_count), PERF ? 64'(exp_fetch_cnt) : 64'h0);
        check({tag, "_perf_drop"}, 64'(bus.perf_drop_count), PERF ? 64'(exp_drop_cnt) : 64'h0);
    endtask

    vec_t vecs[5];

    initial begin
        int          base;
        int          req0;
        logic [63:0] held_addr;

        vecs[0] = '{64'h100, 2, 4, 64'h10C, 1'b0};
        vecs[1] = '{64'h200, 5, 3, 64'h208, 1'b0};
        vecs[2] = '{64'h3F4, 3, 4, 64'h400, 1'b1};
        vecs[3] = '{64'h002, 2, 1, 64'h002, 1'b1};
        vecs[4] = '{64'h800, 4, 1, 64'h800, 1'b1};

        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 64'h0;
        bus.deq_ready       = 1'b1;

        // Reset values, then first request straight after reset.
        repeat (3) tick();
        #1;
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'h0);
        check("rst_deq_valid", 64'(bus.deq_valid), 64'h0);
        check("rst_deq_pc", bus.deq_pc, 64'h0);
        check("rst_deq_instr", 64'(bus.deq_instruction), 64'h0);
        check("rst_deq_inv", 64'(bus.deq_inv_addr), 64'h0);
        check("rst_queue_count", 64'(bus.queue_count), 64'h0);
        reset = 1'b0;
        #1;
        check("first_req_valid", 64'(bus.imem_req_valid), 64'h1);
        check("first_req_addr", bus.imem_req_addr, RESET_PC);

        // Straight-line fetch with immediate consumption.
        base = deq_log.size();
        run_until_deq("t1_deq_timeout", 3, 40);
        check("t1_pc0", deq_log[base], 64'h0);
        check("t1_pc1", deq_log[base + 1], 64'h4);
        check("t1_pc2", deq_log[base + 2], 64'h8);
        check("t1_instr2", 64'(deq_instr_log[base + 2]), 64'(mem_word(64'h8)));
        check("t1_inv2", 64'(deq_inv_log[base + 2]), 64'h0);

        // Consumer stalled: queue fills and requests stop.
        bus.deq_ready = 1'b0;
        repeat (20) tick();
        #1;
        check("t2_full_count", 64'(bus.queue_count), 64'(DEPTH));
        check("t2_full_req_valid", 64'(bus.imem_req_valid), 64'h0);
        bus.deq_ready = 1'b1;
        run_until_deq("t2_drain_timeout", 4, 40);
        req0 = n_req;
        for (int i = 0; i < 20 && n_req == req0; i++) tick();
        check("t2_fetch_resumes", 64'(n_req > req0), 64'h1);

        // Redirect while a response is outstanding.
        for (int i = 0; i < 20 && !mem_pending; i++) tick();
        check("t3_in_wait", 64'(mem_pending), 64'h1);
        redirect_to(64'h40);
        #1;
        check("t3_flushed_count", 64'(bus.queue_count), 64'h0);
        check("t3_drain_no_req", 64'(bus.imem_req_valid), 64'h0);
        base = deq_log.size();
        run_until_deq("t3_deq_timeout", 1, 40);
        check("t3_first_pc", deq_log[base], 64'h40);
        check_perf("t3");

        // Memory back-pressure: request held stable until accepted.
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 40 && !bus.imem_req_valid; i++) tick();
        held_addr = exp_fetch_pc;
        for (int k = 0; k < 3; k++) begin
            check("t4_held_valid", 64'(bus.imem_req_valid), 64'h1);
            check("t4_held_addr", bus.imem_req_addr, held_addr);
            tick();
        end
        bus.imem_req_ready = 1'b1;
        req0 = n_req;
        check("t4_valid_cycle4", 64'(bus.imem_req_valid), 64'h1);
        tick();
        check("t4_accepted_cycle4", 64'(n_req - req0), 64'h1);

        // End of memory: last word, invalid marker, then silence.
        redirect_to(64'h3FC);
        base = deq_log.size();
        run_until_deq("t5_deq_timeout", 2, 60);
        check("t5_last_valid_pc", deq_log[base], 64'h3FC);
        check("t5_inv_pc", deq_log[base + 1], 64'h400);
        check("t5_inv_instr", 64'(deq_instr_log[base + 1]), 64'h13);
        check("t5_inv_flag", 64'(deq_inv_log[base + 1]), 64'h1);
        req0 = n_req;
        repeat (10) tick();
        check("t5_halt_no_req", 64'(n_req - req0), 64'h0);
        check("t5_halt_req_valid", 64'(bus.imem_req_valid), 64'h0);
        redirect_to(64'h0);
        base = deq_log.size();
        run_until_deq("t5_restart_timeout", 1, 40);
        check("t5_restart_pc", deq_log[base], 64'h0);

        // Redirect vector table.
        foreach (vecs[v]) begin
            lat = vecs[v].lat;
            redirect_to(vecs[v].start_pc);
            base = deq_log.size();
            run_until_deq("vec_deq_timeout", vecs[v].n_deq, 80);
            check("vec_first_pc", deq_log[base], vecs[v].start_pc);
            check("vec_last_pc", deq_log[deq_log.size() - 1], vecs[v].exp_last_pc);
            check("vec_last_inv", 64'(deq_inv_log[deq_inv_log.size() - 1]), 64'(vecs[v].exp_last_inv));
        end
        check_perf("vec");

        // Reset with a request outstanding and two entries queued.
        lat = 3;
        redirect_to(64'h20);
        bus.deq_ready = 1'b0;
        for (int i = 0; i < 40 && !(sb.size() == 2 && mem_pending); i++) tick();
        check("t6_precondition_count", 64'(bus.queue_count), 64'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t6_count", 64'(bus.queue_count), 64'h0);
        check("t6_deq_valid", 64'(bus.deq_valid), 64'h0);
        check("t6_deq_pc", bus.deq_pc, 64'h0);
        check("t6_req_valid", 64'(bus.imem_req_valid), 64'h1);
        check("t6_req_addr", bus.imem_req_addr, RESET_PC);
        bus.deq_ready = 1'b1;
        base = deq_log.size();
        run_until_deq("t6_deq_timeout", 2, 40);
        check("t6_first_pc", deq_log[base], RESET_PC);
        check("t6_second_pc", deq_log[base + 1], RESET_PC + 64'd4);
        check_perf("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
Fetch-side block upstream of the IF/ID pipeline register. It issues sequential word fetches to a multi-cycle instruction memory and buffers the returned instructions in a small FIFO tagged with their PC. It presents them to IF/ID through a valid/ready handshake, where ready is IF_ID_Write. On a redirect (branch taken), it flushes all buffered and in-flight fetches and restarts fetching from the new PC.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
RESET_PC, 64'h0, first fetch address after reset
IMEM_BYTES, 1024, instruction memory size in bytes; addresses >= this are invalid

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  64  byte address of fetch
imem_req_ready  input  1  memory accepts request
imem_resp_valid  input  1  response valid (one per accepted request)
imem_resp_data  input  32  fetched instruction
redirect_valid  input  1  flush and refetch
redirect_pc  input  64  new fetch PC
deq_ready  input  1  consumer accepts head (IF_ID_Write)
deq_valid  output  1  head entry valid
deq_pc  output  64  PC of head
deq_instruction  output  32  instruction of head
deq_inv_addr  output  1  head produced by an invalid fetch address
queue_count  output  $clog2(DEPTH+1)  occupied entries
perf_fetch_count  output  32  see Optional Feature
perf_drop_count  output  32  see Optional Feature

Behaviour:
- Reset: fetch_pc=RESET_PC; FIFO empty; state FETCH; imem_req_valid=0, deq_valid=0, deq_pc=0, deq_instruction=0, deq_inv_addr=0, queue_count=0. Reset mid-operation abandons any outstanding request. The memory shares the same reset.
- Space: space = (queue_count + inflight) < DEPTH. inflight is 1 in state WAIT, else 0. The FIFO therefore never overflows.
- States: FETCH, WAIT, DRAIN, HALT.
- FETCH, fetch_pc valid (fetch_pc[1:0]==0 and fetch_pc < IMEM_BYTES):
  - imem_req_valid = space; imem_req_addr = fetch_pc.
  - Once asserted, valid and addr are held stable until imem_req_ready. Space cannot shrink without a redirect.
  - On handshake: req_pc<=fetch_pc; fetch_pc<=fetch_pc+4 (64-bit wrap); go to WAIT.
- FETCH, fetch_pc invalid:
  - No memory request is issued.
  - If space: enqueue {fetch_pc, 32'h00000013, inv=1}; go to HALT.
- WAIT: on imem_resp_valid, enqueue {req_pc, imem_resp_data, inv=0}; go to FETCH. The next request is asserted the following cycle (2-cycle minimum per fetch plus memory latency).
- DRAIN: an old response is still outstanding. The next imem_resp_valid is discarded; go to FETCH.
- HALT: no requests; stays until redirect.
- imem_resp_valid is ignored in FETCH and HALT.
- Dequeue:
  - deq_valid = !empty && !redirect_valid; head fields are driven from the FIFO read pointer.
  - Pop when deq_valid && deq_ready.
  - Enqueue and pop in the same cycle are both performed; queue_count is unchanged.
- Redirect (highest priority, any state):
  - Next cycle: FIFO empty, queue_count=0, fetch_pc=redirect_pc.
  - Pending enqueue and pop in that cycle are dropped.
  - Next state:
    - DRAIN if state was WAIT without resp_valid this cycle.
    - DRAIN if a request handshake occurs in that cycle.
    - DRAIN if already in DRAIN without resp_valid.
    - Otherwise FETCH.
  - A pending, unaccepted request is withdrawn (imem_req_valid may drop without ready only on redirect).
  - Back-to-back redirects: the latest redirect_pc wins.
- Pointers: log2(DEPTH) bits, natural wrap-around. Full is indicated by queue_count==DEPTH.

Optional Feature:
Macro PREFETCH_PERF_CNT_EN.
- Defined:
  - perf_fetch_count increments on each accepted imem request.
  - perf_drop_count increments on each discarded response plus each entry flushed by a redirect (adds queue_count in that cycle).
  - Both counters are 32-bit, wrap, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are present.

Test Plan:
- Reset; memory responds 2 cycles after accept; deq_ready=1 -> deq sequence pc 0x0,0x4,0x8 with the matching memory words in order; deq_inv_addr=0.
- deq_ready=0 for 20 cycles -> queue_count reaches 4, imem_req_valid stays 0 after the 4th fetch; deq_ready=1 -> 4 entries drain in order, fetching resumes.
- Redirect to 0x40 while in WAIT -> old response discarded; first deq_pc=0x40; perf_drop_count=1 if enabled.
- imem_req_ready held 0 for 3 cycles -> imem_req_valid=1 and imem_req_addr constant throughout; accepted on cycle 4.
- Redirect to 0x3FC, IMEM_BYTES=1024 -> entry 0x3FC fetched normally, then entry pc 0x400, instruction 0x00000013, deq_inv_addr=1; no further requests until redirect to 0x0.
- Reset asserted in WAIT with 2 entries queued -> next cycle queue_count=0, deq_valid=0, first request addr=RESET_PC.
